// File: rtl/clk_div_pkg.sv
// Shared defaults and per-channel state type for the clock divider bank.
package clk_div_pkg;

  localparam int unsigned NumChDef  = 4;
  localparam int unsigned DivWDef   = 8;
  localparam int unsigned DefDivDef = 3;

  // Single-bit channel state; the divisor-wide registers live beside it in clk_div_ch.
  typedef struct packed {
    logic pending;
    logic clk_out;
    logic tick;
  } ch_state_t;

  localparam ch_state_t ChStateRst = '{pending: 1'b0, clk_out: 1'b0, tick: 1'b0};

endpackage

// File: rtl/clk_div_ch.sv
// One divider channel: active/shadow divisor, period counter, registered level and strobe.
module clk_div_ch
  import clk_div_pkg::*;
#(
  parameter int unsigned DIV_W   = DivWDef,
  parameter int unsigned DEF_DIV = DefDivDef
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             resync,
  input  logic [DIV_W-1:0] div_val,
  input  logic             div_load,
  output logic             clk_out,
  output logic             tick,
  output logic             div_pending
);

  localparam logic [DIV_W-1:0] One    = DIV_W'(1);
  localparam logic [DIV_W-1:0] Two    = DIV_W'(2);
  localparam logic [DIV_W-1:0] RstDiv = DIV_W'(DEF_DIV);
  localparam logic [DIV_W-1:0] RstCnt = DIV_W'(DEF_DIV - 1);

  logic [DIV_W-1:0] act_q, act_d;
  logic [DIV_W-1:0] shd_q, shd_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  ch_state_t        st_q, st_d;
  logic             wrap;
  logic             apply;

  // Next-state: divisor hand-over, counter advance/park, output level and strobe.
  always_comb begin
    act_d = act_q;
    shd_d = shd_q;
    cnt_d = cnt_q;
    st_d  = st_q;

    // Divisors below 2 make every enabled edge a period boundary.
    wrap  = en && (resync || (act_q < Two) || (cnt_q >= act_q - One));
    // A load on this very edge postpones hand-over so only the newest value lands.
    apply = st_q.pending && !div_load && (wrap || !en);

    if (apply) begin
      act_d        = shd_q;
      st_d.pending = 1'b0;
    end
    if (div_load) begin
      shd_d        = div_val;
      st_d.pending = 1'b1;
    end

    if (!en) begin
      // Parked one short of the end so the first enabled edge wraps cleanly.
      cnt_d        = act_d - One;
      st_d.clk_out = 1'b0;
      st_d.tick    = 1'b0;
    end else if (act_d < Two) begin
      cnt_d        = '0;
      st_d.clk_out = 1'b0;
      st_d.tick    = 1'b1;
    end else begin
      cnt_d        = wrap ? '0 : cnt_q + One;
      st_d.clk_out = cnt_d < (act_d >> 1);
      st_d.tick    = cnt_d == (act_d - One);
    end
  end

  // State registers with asynchronous reset to the default divisor.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_q <= RstDiv;
      shd_q <= RstDiv;
      cnt_q <= RstCnt;
      st_q  <= ChStateRst;
    end else begin
      act_q <= act_d;
      shd_q <= shd_d;
      cnt_q <= cnt_d;
      st_q  <= st_d;
    end
  end

  assign clk_out     = st_q.clk_out;
  assign tick        = st_q.tick;
  assign div_pending = st_q.pending;

endmodule

// File: rtl/clk_div_bank.sv
// Bank of NUM_CH independent clock dividers with glitch-free divisor reload.
// Define CLK_DIV_BANK_RESYNC_EN to add the resync input that phase-aligns all
// enabled channels by forcing them to wrap on the same edge.
module clk_div_bank
  import clk_div_pkg::*;
#(
  parameter int unsigned NUM_CH  = NumChDef,
  parameter int unsigned DIV_W   = DivWDef,
  parameter int unsigned DEF_DIV = DefDivDef
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_CH-1:0]       en,
  input  logic [NUM_CH*DIV_W-1:0] div_val,
  input  logic [NUM_CH-1:0]       div_load,
`ifdef CLK_DIV_BANK_RESYNC_EN
  input  logic                    resync,
`endif
  output logic [NUM_CH-1:0]       clk_out,
  output logic [NUM_CH-1:0]       tick,
  output logic [NUM_CH-1:0]       div_pending
);

  logic resync_all;

`ifdef CLK_DIV_BANK_RESYNC_EN
  assign resync_all = resync;
`else
  assign resync_all = 1'b0;
`endif

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    clk_div_ch #(
      .DIV_W  (DIV_W),
      .DEF_DIV(DEF_DIV)
    ) u_ch (
      .clk        (clk),
      .rst_n      (rst_n),
      .en         (en[i]),
      .resync     (resync_all),
      .div_val    (div_val[i*DIV_W +: DIV_W]),
      .div_load   (div_load[i]),
      .clk_out    (clk_out[i]),
      .tick       (tick[i]),
      .div_pending(div_pending[i])
    );
  end

endmodule

// File: tb/tb_clk_div_bank.sv
// Directed bench for clk_div_bank: vector table plus hand-written corner sequences.
module tb_clk_div_bank;

  localparam int unsigned NumCh = 4;
  localparam int unsigned DivW  = 8;

  logic                  clk;
  logic                  rst_n;
  logic [NumCh-1:0]      en;
  logic [NumCh*DivW-1:0] div_val;
  logic [NumCh-1:0]      div_load;
`ifdef CLK_DIV_BANK_RESYNC_EN
  logic                  resync;
`endif
  logic [NumCh-1:0]      clk_out;
  logic [NumCh-1:0]      tick;
  logic [NumCh-1:0]      div_pending;

  int n_checks = 0;
  int n_fail   = 0;

  clk_div_bank #(
    .NUM_CH (NumCh),
    .DIV_W  (DivW),
    .DEF_DIV(3)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .div_val    (div_val),
    .div_load   (div_load),
`ifdef CLK_DIV_BANK_RESYNC_EN
    .resync     (resync),
`endif
    .clk_out    (clk_out),
    .tick       (tick),
    .div_pending(div_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  en;
    logic [3:0]  ld;
    logic [31:0] dv;
    logic [3:0]  exp_clk;
    logic [3:0]  exp_tick;
    logic [3:0]  exp_pend;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [3:0] e, input logic [3:0] ld, input int ch,
                     input logic [7:0] v, input logic [3:0] c, input logic [3:0] t,
                     input logic [3:0] p);
    vec_t x;
    x.en       = e;
    x.ld       = ld;
    x.dv       = '0;
    x.dv[ch*8 +: 8] = v;
    x.exp_clk  = c;
    x.exp_tick = t;
    x.exp_pend = p;
    vecs.push_back(x);
  endtask

  task automatic check4(input string name, input logic [3:0] got, input logic [3:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, got, exp);
    end
  endtask

  task automatic check1(input string name, input logic got, input logic exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, got, exp);
    end
  endtask

  task automatic drive(input logic [3:0] e, input logic [3:0] ld, input int ch,
                       input logic [7:0] v);
    logic [31:0] d;
    d = '0;
    d[ch*8 +: 8] = v;
    en       = e;
    div_load = ld;
    div_val  = d;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n    = 1'b0;
    en       = '0;
    div_val  = '0;
    div_load = '0;
`ifdef CLK_DIV_BANK_RESYNC_EN
    resync   = 1'b0;
`endif

    // Divide-by-3 default on ch0, then ch1 reload 4 -> 6 -> (5,7), then ch2 divide-by-1.
    add(4'b0001, 4'b0000, 0, 0, 4'b0001, 4'b0000, 4'b0000);
    add(4'b0001, 4'b0000, 0, 0, 4'b0000, 4'b0000, 4'b0000);
    add(4'b0001, 4'b0000, 0, 0, 4'b0000, 4'b0001, 4'b0000);
    add(4'b0001, 4'b0000, 0, 0, 4'b0001, 4'b0000, 4'b0000);
    add(4'b0001, 4'b0000, 0, 0, 4'b0000, 4'b0000, 4'b0000);
    add(4'b0001, 4'b0000, 0, 0, 4'b0000, 4'b0001, 4'b0000);
    add(4'b0000, 4'b0010, 1, 4, 4'b0000, 4'b0000, 4'b0010);
    add(4'b0000, 4'b0000, 0, 0, 4'b0000, 4'b0000, 4'b0000);
    add(4'b0010, 4'b0000, 0, 0, 4'b0010, 4'b0000, 4'b0000);
    add(4'b0010, 4'b0000, 0, 0, 4'b0010, 4'b0000, 4'b0000);
    add(4'b0010, 4'b0010, 1, 6, 4'b0000, 4'b0000, 4'b0010);
    add(4'b0010, 4'b0000, 0, 0, 4'b0000, 4'b0010, 4'b0010);
    add(4'b0010, 4'b0000, 0, 0, 4'b0010, 4'b0000, 4'b0000);
    add(4'b0010, 4'b0000, 0, 0, 4'b0010, 4'b0000, 4'b0000);
    add(4'b0010, 4'b0000, 0, 0, 4'b0010, 4'b0000, 4'b0000);
    add(4'b0010, 4'b0000, 0, 0, 4'b0000, 4'b0000, 4'b0000);
    add(4'b0010, 4'b0000, 0, 0, 4'b0000, 4'b0000, 4'b0000);
    add(4'b0010, 4'b0000, 0, 0, 4'b0000, 4'b0010, 4'b0000);
    add(4'b0010, 4'b0000, 0, 0, 4'b0010, 4'b0000, 4'b0000);
    add(4'b0010, 4'b0010, 1, 5, 4'b0010, 4'b0000, 4'b0010);
    add(4'b0010, 4'b0010, 1, 7, 4'b0010, 4'b0000, 4'b0010);
    add(4'b0010, 4'b0000, 0, 0, 4'b0000, 4'b0000, 4'b0010);
    add(4'b0010, 4'b0000, 0, 0, 4'b0000, 4'b0000, 4'b0010);
    add(4'b0010, 4'b0000, 0, 0, 4'b0000, 4'b0010, 4'b0010);
    add(4'b0010, 4'b0000, 0, 0, 4'b0010, 4'b0000, 4'b0000);
    add(4'b0010, 4'b0000, 0, 0, 4'b0010, 4'b0000, 4'b0000);
    add(4'b0010, 4'b0000, 0, 0, 4'b0010, 4'b0000, 4'b0000);
    add(4'b0010, 4'b0000, 0, 0, 4'b0000, 4'b0000, 4'b0000);
    add(4'b0010, 4'b0000, 0, 0, 4'b0000, 4'b0000, 4'b0000);
    add(4'b0010, 4'b0000, 0, 0, 4'b0000, 4'b0000, 4'b0000);
    add(4'b0010, 4'b0000, 0, 0, 4'b0000, 4'b0010, 4'b0000);
    add(4'b0010, 4'b0000, 0, 0, 4'b0010, 4'b0000, 4'b0000);
    add(4'b0010, 4'b0100, 2, 1, 4'b0010, 4'b0000, 4'b0100);
    add(4'b0010, 4'b0000, 0, 0, 4'b0010, 4'b0000, 4'b0000);
    add(4'b0110, 4'b0000, 0, 0, 4'b0000, 4'b0100, 4'b0000);
    add(4'b0110, 4'b0000, 0, 0, 4'b0000, 4'b0100, 4'b0000);
    add(4'b0110, 4'b0000, 0, 0, 4'b0000, 4'b0100, 4'b0000);
    add(4'b0110, 4'b0000, 0, 0, 4'b0000, 4'b0110, 4'b0000);
    add(4'b0110, 4'b0000, 0, 0, 4'b0010, 4'b0100, 4'b0000);

    // Reset state.
    step();
    step();
    check4("reset clk_out", clk_out, 4'b0000);
    check4("reset tick", tick, 4'b0000);
    check4("reset div_pending", div_pending, 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      drive(vecs[i].en, vecs[i].ld, 0, 0);
      div_val = vecs[i].dv;
      step();
      check4($sformatf("vec%0d clk_out", i), clk_out, vecs[i].exp_clk);
      check4($sformatf("vec%0d tick", i), tick, vecs[i].exp_tick);
      check4($sformatf("vec%0d div_pending", i), div_pending, vecs[i].exp_pend);
    end

    // ch3 at D=4: drop en at cnt=1, re-enable after three idle edges.
    drive(4'b0000, 4'b1000, 3, 4); step();
    check1("en_drop load pend", div_pending[3], 1'b1);
    drive(4'b0000, 4'b0000, 0, 0); step();
    check1("en_drop idle apply pend", div_pending[3], 1'b0);
    check1("en_drop idle clk", clk_out[3], 1'b0);
    drive(4'b1000, 4'b0000, 0, 0); step();
    check1("en_drop first edge clk", clk_out[3], 1'b1);
    step();
    check1("en_drop cnt1 clk", clk_out[3], 1'b1);
    drive(4'b0000, 4'b0000, 0, 0); step();
    check1("en_drop truncate clk", clk_out[3], 1'b0);
    check1("en_drop truncate tick", tick[3], 1'b0);
    step();
    step();
    check1("en_drop parked clk", clk_out[3], 1'b0);
    drive(4'b1000, 4'b0000, 0, 0); step();
    check1("en_drop restart clk", clk_out[3], 1'b1);
    check1("en_drop restart tick", tick[3], 1'b0);
    step();
    check1("en_drop p1 clk", clk_out[3], 1'b1);
    step();
    check1("en_drop p2 clk", clk_out[3], 1'b0);
    step();
    check1("en_drop p3 clk", clk_out[3], 1'b0);
    check1("en_drop p3 tick", tick[3], 1'b1);
    step();
    check1("en_drop p4 clk", clk_out[3], 1'b1);

    // ch0 at D=3: load 5 on the wrap edge itself, expect one more D=3 period first.
    drive(4'b0001, 4'b0001, 0, 5); step();
    check1("wrap_load clk", clk_out[0], 1'b1);
    check1("wrap_load pend", div_pending[0], 1'b1);
    drive(4'b0001, 4'b0000, 0, 0); step();
    check1("wrap_load c2 clk", clk_out[0], 1'b0);
    step();
    check1("wrap_load c3 tick", tick[0], 1'b1);
    check1("wrap_load c3 pend", div_pending[0], 1'b1);
    step();
    check1("wrap_load apply clk", clk_out[0], 1'b1);
    check1("wrap_load apply pend", div_pending[0], 1'b0);
    step();
    check1("wrap_load d5 c1 clk", clk_out[0], 1'b1);
    step();
    check1("wrap_load d5 c2 clk", clk_out[0], 1'b0);
    step();
    check1("wrap_load d5 c3 tick", tick[0], 1'b0);
    step();
    check1("wrap_load d5 c4 tick", tick[0], 1'b1);

    // Reset mid-operation discards ch1's pending load and restores D=3.
    drive(4'b0001, 4'b0010, 1, 9); step();
    check1("midrst pre clk", clk_out[0], 1'b1);
    check1("midrst pre pend", div_pending[1], 1'b1);
    rst_n = 1'b0;
    drive(4'b0000, 4'b0000, 0, 0);
    #1;
    check4("midrst async clk_out", clk_out, 4'b0000);
    check4("midrst async pend", div_pending, 4'b0000);
    step();
    @(negedge clk);
    rst_n = 1'b1;
    drive(4'b0011, 4'b0000, 0, 0); step();
    check4("midrst c1 clk", clk_out, 4'b0011);
    check4("midrst c1 tick", tick, 4'b0000);
    step();
    check4("midrst c2 clk", clk_out, 4'b0000);
    step();
    check4("midrst c3 clk", clk_out, 4'b0000);
    check4("midrst c3 tick", tick, 4'b0011);

`ifdef CLK_DIV_BANK_RESYNC_EN
    // ch0 D=4 and ch1 D=6 started out of phase, then aligned by resync.
    drive(4'b0000, 4'b0001, 0, 4); step();
    drive(4'b0000, 4'b0010, 1, 6); step();
    drive(4'b0000, 4'b0000, 0, 0); step();
    drive(4'b0001, 4'b0000, 0, 0); step();
    drive(4'b0011, 4'b0000, 0, 0); step();
    check4("resync pre1 clk", clk_out, 4'b0011);
    step();
    check4("resync pre2 clk", clk_out, 4'b0010);
    resync = 1'b1;
    step();
    check4("resync edge clk", clk_out, 4'b0011);
    check4("resync edge tick", tick, 4'b0000);
    resync = 1'b0;
    step();
    check4("resync post1 clk", clk_out, 4'b0011);
    step();
    check4("resync post2 clk", clk_out, 4'b0010);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/clk_div_bank.md
CLK_DIV_BANK -- requirements
Module: clk_div_bank

Interface
REQ-001 SHALL have parameter NUM_CH, default 4: number of independent divider channels (1..16).
REQ-002 SHALL have parameter DIV_W, default 8: divisor width in bits.
REQ-003 SHALL have parameter DEF_DIV, default 3: divisor loaded into every channel at reset (2..2^DIV_W-1).
REQ-004 SHALL have port clk  input  1  sole clock; all logic on posedge.
REQ-005 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port en  input  NUM_CH  per-channel run enable.
REQ-007 SHALL have port div_val  input  NUM_CH*DIV_W  per-channel new divisor; channel i in bits [i*DIV_W +: DIV_W].
REQ-008 SHALL have port div_load  input  NUM_CH  per-channel single-cycle load strobe for div_val.
REQ-009 SHALL have port clk_out  output  NUM_CH  registered divided-clock level.
REQ-010 SHALL have port tick  output  NUM_CH  registered one-cycle strobe marking the last cycle of each period.
REQ-011 SHALL have port div_pending  output  NUM_CH  high while a loaded divisor awaits application.

Function
REQ-012 Each channel SHALL hold act_div (active), shd_div (shadow), pending flag and counter cnt of DIV_W bits.
REQ-013 With en=1 and act_div>=2, cnt SHALL advance per edge: cnt==act_div-1 -> 0 (wrap), else cnt+1.
REQ-014 clk_out SHALL be registered as (new cnt < act_div/2, floor); high floor(D/2) cycles, low ceil(D/2) cycles per period D.
REQ-015 tick SHALL be registered as (new cnt == act_div-1); exactly one pulse per period.
REQ-016 With en=0, cnt SHALL be parked at act_div-1; clk_out=0; tick=0.
REQ-017 First enabled edge after idle SHALL wrap cnt to 0 and drive clk_out=1 with no runt pulse.
REQ-018 act_div of 0 or 1 SHALL give clk_out=0 and tick=1 on every enabled cycle (divide-by-1 strobe).
REQ-019 div_load=1 SHALL capture div_val into shd_div and set pending on the same edge.
REQ-020 Pending divisor SHALL transfer to act_div on the next wrap edge (not the load edge itself); pending clears on that edge.
REQ-021 With en=0, pending divisor SHALL apply on the edge after load, with cnt re-parked to new act_div-1.
REQ-022 A load while pending SHALL overwrite shd_div; only the latest value applies.
REQ-023 div_load coincident with a wrap SHALL defer application to the following wrap.
REQ-024 en falling mid-period SHALL truncate immediately (clk_out=0 next edge); pending is retained.
REQ-025 Channels SHALL be fully independent except for the resync feature.

Reset
REQ-026 rst_n low SHALL asynchronously set act_div=shd_div=DEF_DIV, pending=0, cnt=DEF_DIV-1, clk_out=0, tick=0, div_pending=0.
REQ-027 Reset asserted mid-operation SHALL discard pending loads; release is assumed synchronised externally.

Configuration
REQ-028 Macro CLK_DIV_BANK_RESYNC_EN defined SHALL add input port resync (1 bit).
REQ-029 With it, resync=1 SHALL force every enabled channel to wrap on that edge (cnt=0, clk_out=1, pending applied), phase-aligning all channels.
REQ-030 Without it, no resync port SHALL exist and channels align only via en.

Structure
REQ-031 Package clk_div_pkg SHALL hold DIV_W/NUM_CH defaults, DEF_DIV and a per-channel state struct typedef.
REQ-032 Per-channel logic SHALL live in sub-module clk_div_ch, instantiated NUM_CH times by generate loop.

Verification
REQ-033 Reset, en[0]=1, DEF_DIV=3 -> clk_out[0] pattern 1,0,0 repeating; tick[0] on every third cycle with clk_out low.
REQ-034 Running D=4, load 6 mid-period -> div_pending=1 until wrap, then period 6 (3 high, 3 low); no runt.
REQ-035 Loads 5 then 7 within one period -> only 7 applied at wrap.
REQ-036 Load 1 on channel 2 -> clk_out[2]=0, tick[2]=1 each cycle; other channels unchanged.
REQ-037 en dropped at cnt=1 of D=4, re-enabled 3 cycles later -> clk_out restarts high on first enabled edge.
REQ-038 With CLK_DIV_BANK_RESYNC_EN, channels D=4 and D=6 out of phase, pulse resync -> both clk_out rise together next edge.
